gsim_solver: RTL and testbench

GSIM_SOLVER -- requirements
Module: gsim_solver

---
 rtl/gsim_pkg.sv | 19 +
 rtl/gsim_update.sv | 50 +++++
 rtl/gsim_solver.sv | 158 +++++++++++++++
 tb/tb_gsim_solver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared types and constants for the banded-Toeplitz Gauss-Seidel solver.
// The reciprocal 13107 / 2^18 approximates 1/20 so the diagonal divide becomes a multiply.
package gsim_pkg;

   typedef enum logic [1:0] {
      S_RECV = 2'd0,
      S_CALC = 2'd1,
      S_SEND = 2'd2
   } state_t;

   localparam int signed C_DIAG     = 20;
   localparam int signed C_D1       = 13;
   localparam int signed C_D2       = 6;
   localparam int signed C_D3       = 1;
   localparam int signed C_RECIP    = 13107;
   localparam int signed C_RECIP_SH = 18;
   localparam int signed C_FRAC     = 16;

endpackage

// File: rtl/gsim_update.sv
// Single Gauss-Seidel element update: weighted neighbour sum, reciprocal scale,
// saturation to the x range and absolute change against the previous value.
module gsim_update
   import gsim_pkg::*;
#(
   parameter int BW = 16,
   parameter int XW = 32
) (
   input  logic signed [BW-1:0] b_i,
   input  logic signed [XW-1:0] x_old,
   input  logic signed [XW-1:0] xm3,
   input  logic signed [XW-1:0] xm2,
   input  logic signed [XW-1:0] xm1,
   input  logic signed [XW-1:0] xp1,
   input  logic signed [XW-1:0] xp2,
   input  logic signed [XW-1:0] xp3,
   output logic signed [XW-1:0] x_new,
   output logic        [XW:0]   delta
);

   localparam int SW = XW + 8;
   localparam int PW = SW + 16;

   logic signed [SW-1:0] s;
   logic signed [PW-1:0] p;
   logic signed [PW-1:0] q;
   logic signed [XW:0]   diff;

   function automatic logic signed [XW-1:0] sat_xw(input logic signed [PW-1:0] v);
      if ((&v[PW-1:XW-1]) || (~|v[PW-1:XW-1]))
         return $signed(v[XW-1:0]);
      else if (v[PW-1])
         return $signed({1'b1, {(XW-1){1'b0}}});
      else
         return $signed({1'b0, {(XW-1){1'b1}}});
   endfunction

   always_comb begin
      s = (SW'(b_i) <<< C_FRAC)
        + SW'(C_D1) * (SW'(xm1) + SW'(xp1))
        - SW'(C_D2) * (SW'(xm2) + SW'(xp2))
        + SW'(C_D3) * (SW'(xm3) + SW'(xp3));
      p     = PW'(s) * PW'(C_RECIP);
      q     = p >>> C_RECIP_SH;
      x_new = sat_xw(q);
      diff  = (XW+1)'(x_new) - (XW+1)'(x_old);
      delta = diff[XW] ? $unsigned(-diff) : $unsigned(diff);
   end

endmodule

// File: rtl/gsim_solver.sv
// Receives N b samples, runs Gauss-Seidel sweeps one element per cycle on a
// banded Toeplitz system, then streams x back out under a valid/ready handshake.
module gsim_solver
   import gsim_pkg::*;
#(
   parameter int N          = 16,
   parameter int BW         = 16,
   parameter int XW         = 32,
   parameter int ITER_W     = 8,
   parameter int WARM_START = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_en,
   input  logic signed [BW-1:0]    b_in,
   input  logic [ITER_W-1:0]       iter_max,
   input  logic [XW-1:0]           tol,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [XW-1:0]    x_out,
   output logic [$clog2(N)-1:0]    out_idx,
   output logic [ITER_W-1:0]       iter_used
);

   localparam int             IW   = $clog2(N);
   localparam logic [IW-1:0]  LAST = IW'(N - 1);

   state_t                 state;
   logic [IW-1:0]          cnt;
   logic [IW-1:0]          k;
   logic signed [BW-1:0]   b_mem [N];
   logic signed [XW-1:0]   x_mem [N];
   logic [ITER_W-1:0]      iter_max_r;
   logic [XW-1:0]          tol_r;
   logic [XW:0]            max_d;

   logic signed [XW-1:0]   nbr [6];
   logic signed [XW-1:0]   x_new;
   logic [XW:0]            delta;
   logic [XW:0]            md_next;
   logic [ITER_W-1:0]      it_next;
   logic [ITER_W-1:0]      eff_max;
   logic                   done;
   int                     nj;

   // Neighbours at offsets -3..-1 and +1..+3; lower indices already hold this sweep's values.
   always_comb begin
      nj = 0;
      for (int d = 0; d < 6; d++) begin
         nbr[d] = '0;
         nj = int'(k) + ((d < 3) ? (d - 3) : (d - 2));
         if (nj >= 0 && nj < N)
            nbr[d] = x_mem[nj[IW-1:0]];
      end
   end

   gsim_update #(
      .BW (BW),
      .XW (XW)
   ) u_update (
      .b_i   (b_mem[k]),
      .x_old (x_mem[k]),
      .xm3   (nbr[0]),
      .xm2   (nbr[1]),
      .xm1   (nbr[2]),
      .xp1   (nbr[3]),
      .xp2   (nbr[4]),
      .xp3   (nbr[5]),
      .x_new (x_new),
      .delta (delta)
   );

   assign md_next = (delta > max_d) ? delta : max_d;
   assign it_next = iter_used + ITER_W'(1);
   assign eff_max = (iter_max_r == '0) ? ITER_W'(1) : iter_max_r;
   assign done    = (it_next == eff_max) ||
                    ((tol_r != '0) && (md_next <= {1'b0, tol_r}));
   assign busy    = (state != S_RECV);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_RECV;
         cnt        <= '0;
         k          <= '0;
         iter_used  <= '0;
         iter_max_r <= '0;
         tol_r      <= '0;
         max_d      <= '0;
         out_valid  <= 1'b0;
         x_out      <= '0;
         out_idx    <= '0;
         for (int i = 0; i < N; i++) begin
            b_mem[i] <= '0;
            x_mem[i] <= '0;
         end
      end else begin
         case (state)
            S_RECV: begin
               if (in_en) begin
                  b_mem[cnt] <= b_in;
                  if (cnt == '0) begin
                     iter_max_r <= iter_max;
                     tol_r      <= tol;
                  end
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     k         <= '0;
                     iter_used <= '0;
                     max_d     <= '0;
                     if (WARM_START == 0) begin
                        for (int i = 0; i < N; i++)
                           x_mem[i] <= '0;
                     end
                     state <= S_CALC;
                  end else begin
                     cnt <= cnt + IW'(1);
                  end
               end
            end

            S_CALC: begin
               x_mem[k] <= x_new;
               if (k == LAST) begin
                  k         <= '0;
                  max_d     <= '0;
                  iter_used <= it_next;
                  if (done)
                     state <= S_SEND;
               end else begin
                  k     <= k + IW'(1);
                  max_d <= md_next;
               end
            end

            S_SEND: begin
               // One settling cycle after CALC loads the first element before valid rises.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  x_out     <= x_mem[out_idx];
               end else if (out_ready) begin
                  if (out_idx == LAST) begin
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                     state     <= S_RECV;
                  end else begin
                     out_idx <= out_idx + IW'(1);
                     x_out   <= x_mem[out_idx + IW'(1)];
                  end
               end
            end

            default: state <= S_RECV;
         endcase
      end
   end

endmodule

// File: tb/tb_gsim_solver.sv
// Bench for gsim_solver: a cold-start and a warm-start instance driven from
// randomized frames and compared to an arithmetic Gauss-Seidel reference.
module tb_gsim_solver;

   localparam int N      = 16;
   localparam int BW     = 16;
   localparam int XW     = 32;
   localparam int ITER_W = 8;
   localparam int LIM    = N * 256 + 20;
   localparam longint XMAX = 64'sd2147483647;
   localparam longint XMIN = -64'sd2147483648;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  in_en     [2];
   logic signed [BW-1:0]  b_in      [2];
   logic [ITER_W-1:0]     iter_max  [2];
   logic [XW-1:0]         tol       [2];
   logic                  out_ready [2];
   logic                  busy      [2];
   logic                  out_valid [2];
   logic signed [XW-1:0]  x_out     [2];
   logic [3:0]            out_idx   [2];
   logic [ITER_W-1:0]     iter_used [2];

   int     checks = 0;
   int     errors = 0;
   longint mb [2][N];
   longint mx [2][N];
   int     last_iter [2];

   always #5 clk = ~clk;

   gsim_solver #(.N(N), .BW(BW), .XW(XW), .ITER_W(ITER_W), .WARM_START(0)) dut_cold (
      .clk(clk), .reset_n(reset_n), .in_en(in_en[0]), .b_in(b_in[0]),
      .iter_max(iter_max[0]), .tol(tol[0]), .busy(busy[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .x_out(x_out[0]), .out_idx(out_idx[0]), .iter_used(iter_used[0])
   );

   gsim_solver #(.N(N), .BW(BW), .XW(XW), .ITER_W(ITER_W), .WARM_START(1)) dut_warm (
      .clk(clk), .reset_n(reset_n), .in_en(in_en[1]), .b_in(b_in[1]),
      .iter_max(iter_max[1]), .tol(tol[1]), .busy(busy[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .x_out(x_out[1]), .out_idx(out_idx[1]), .iter_used(iter_used[1])
   );

   function automatic longint g(input int sel, input int j);
      if (j < 0 || j >= N) return 0;
      return mx[sel][j];
   endfunction

   // Reference: plain Gauss-Seidel on A = Toeplitz(20, -13, +6, -1), result Q16.
   task automatic model_run(input int sel, input int itm, input longint tolv, output int used);
      longint s, nv, d, md;
      int     eff;
      bit     stop;
      eff  = (itm == 0) ? 1 : itm;
      used = 0;
      stop = 0;
      if (sel == 0)
         for (int i = 0; i < N; i++) mx[0][i] = 0;
      while (!stop) begin
         md = 0;
         for (int i = 0; i < N; i++) begin
            s = mb[sel][i] * 65536
              + 13 * (g(sel, i - 1) + g(sel, i + 1))
              - 6  * (g(sel, i - 2) + g(sel, i + 2))
              +      (g(sel, i - 3) + g(sel, i + 3));
            nv = (s * 13107) >>> 18;
            if (nv > XMAX) nv = XMAX;
            if (nv < XMIN) nv = XMIN;
            d = nv - mx[sel][i];
            if (d < 0) d = -d;
            if (d > md) md = d;
            mx[sel][i] = nv;
         end
         used++;
         if (used == eff || (tolv != 0 && md <= tolv)) stop = 1;
      end
   endtask

   task automatic fill_random(input int sel, input int mag);
      logic [31:0] r;
      for (int i = 0; i < N; i++) begin
         r = $urandom;
         if (mag == 0) mb[sel][i] = longint'($signed(r[15:0]));
         else          mb[sel][i] = longint'($urandom_range(0, 2 * mag)) - longint'(mag);
      end
   endtask

   task automatic send_frame(input int sel, input int itm, input longint tolv, input bit gaps);
      int gap;
      for (int i = 0; i < N; i++) begin
         gap = gaps ? $urandom_range(0, 2) : 0;
         repeat (gap) begin
            in_en[sel] = 1'b0;
            b_in[sel]  = BW'($urandom);
            @(posedge clk); #1;
         end
         in_en[sel]    = 1'b1;
         b_in[sel]     = BW'(mb[sel][i]);
         iter_max[sel] = (i == 0) ? ITER_W'(itm) : ITER_W'($urandom);
         tol[sel]      = (i == 0) ? XW'(tolv)    : XW'($urandom);
         @(posedge clk); #1;
      end
      in_en[sel] = 1'b0;
   endtask

   task automatic wait_out(input int sel, input int used);
      int lat;
      bit got;
      lat = 0;
      got = 0;
      while (lat < LIM && !got) begin
         in_en[sel] = 1'($urandom_range(0, 1));
         b_in[sel]  = BW'($urandom);
         @(posedge clk); #1;
         lat++;
         if (out_valid[sel]) got = 1;
      end
      in_en[sel] = 1'b0;
      last_iter[sel] = int'(iter_used[sel]);
      checks++;
      if (!got || lat != N * used + 1) begin
         errors++;
         $display("FAIL latency sel=%0d got=%0d cycles want=%0d (seen=%0d)", sel, lat, N * used + 1, got);
      end
      checks++;
      if (busy[sel] !== 1'b1) begin
         errors++;
         $display("FAIL busy_send sel=%0d got=%b want=1", sel, busy[sel]);
      end
   endtask

   task automatic drain(input int sel, input int used, input int stall_idx, input int stall_len);
      int          nst;
      logic [31:0] ex;
      for (int idx = 0; idx < N; idx++) begin
         out_ready[sel] = 1'b0;
         nst = (idx == stall_idx) ? stall_len : $urandom_range(0, 1);
         ex  = mx[sel][idx][31:0];
         for (int c = 0; c <= nst; c++) begin
            if (c > 0) begin
               @(posedge clk); #1;
            end
            checks++;
            if (out_valid[sel] !== 1'b1 || out_idx[sel] !== 4'(idx)) begin
               errors++;
               $display("FAIL out_idx sel=%0d got v=%b idx=%0d want v=1 idx=%0d", sel, out_valid[sel], out_idx[sel], idx);
            end
            checks++;
            if (x_out[sel] !== ex) begin
               errors++;
               $display("FAIL x_out sel=%0d idx=%0d got=%h want=%h", sel, idx, x_out[sel], ex);
            end
         end
         checks++;
         if (iter_used[sel] !== ITER_W'(used)) begin
            errors++;
            $display("FAIL iter_used sel=%0d got=%0d want=%0d", sel, iter_used[sel], used);
         end
         out_ready[sel] = 1'b1;
         @(posedge clk); #1;
      end
      out_ready[sel] = 1'b0;
      checks++;
      if (out_valid[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
         errors++;
         $display("FAIL frame_end sel=%0d got v=%b busy=%b want 0 0", sel, out_valid[sel], busy[sel]);
      end
   endtask

   task automatic run_frame(input int sel, input int itm, input longint tolv, input int stall_idx, input int stall_len);
      int used;
      model_run(sel, itm, tolv, used);
      send_frame(sel, itm, tolv, 1'b1);
      wait_out(sel, used);
      drain(sel, used, stall_idx, stall_len);
   endtask

   task automatic check_idle(input string tag);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (busy[s] !== 1'b0 || out_valid[s] !== 1'b0 || x_out[s] !== '0 ||
             out_idx[s] !== '0 || iter_used[s] !== '0) begin
            errors++;
            $display("FAIL %s sel=%0d got busy=%b v=%b x=%h idx=%0d it=%0d want all 0",
                     tag, s, busy[s], out_valid[s], x_out[s], out_idx[s], iter_used[s]);
         end
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         in_en[s] = 1'b0; b_in[s] = '0; iter_max[s] = '0; tol[s] = '0; out_ready[s] = 1'b0;
      end
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;
      check_idle("post_reset");
   endtask

   task automatic test_zero_b();
      for (int i = 0; i < N; i++) mb[0][i] = 0;
      run_frame(0, 5, 1, -1, 0);
   endtask

   task automatic test_impulse();
      for (int i = 0; i < N; i++) mb[0][i] = 0;
      mb[0][0] = 20;
      run_frame(0, 1, 0, -1, 0);
   endtask

   task automatic test_random_long();
      fill_random(0, 0);
      run_frame(0, 70, 0, -1, 0);
   endtask

   task automatic test_backpressure();
      fill_random(0, 0);
      run_frame(0, $urandom_range(1, 6), 0, 5, 3);
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         fill_random(0, 3000);
         run_frame(0, (f == 0) ? 0 : $urandom_range(1, 8), (f == 2) ? longint'($urandom_range(1, 5000)) : 0, -1, 0);
      end
   endtask

   task automatic test_reset_mid_calc();
      int used;
      fill_random(0, 0);
      send_frame(0, 10, 0, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #2;
      check_idle("reset_mid_calc");
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         mx[0][i] = 0;
         mx[1][i] = 0;
      end
      begin
         bit seen;
         seen = 0;
         repeat (200) begin
            @(posedge clk); #1;
            if (out_valid[0] || busy[0]) seen = 1;
         end
         checks++;
         if (seen) begin
            errors++;
            $display("FAIL discard got activity=1 want 0 after reset");
         end
      end
      model_run(0, 10, 0, used);
      send_frame(0, 10, 0, 1'b1);
      wait_out(0, used);
      drain(0, used, -1, 0);
   endtask

   task automatic test_warm_start();
      int it1;
      fill_random(1, 2000);
      run_frame(1, 200, 4, -1, 0);
      it1 = last_iter[1];
      run_frame(1, 200, 4, -1, 0);
      checks++;
      if (last_iter[1] > it1) begin
         errors++;
         $display("FAIL warm_iters got=%0d want<=%0d", last_iter[1], it1);
      end
      // After reset the warm instance must start again from zero.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) mx[1][i] = 0;
      run_frame(1, 200, 4, -1, 0);
   endtask

   initial begin
      test_reset();
      test_zero_b();
      test_impulse();
      test_random_long();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_calc();
      test_warm_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
